sync_fifo_ctrl: RTL and testbench

Single-clock FIFO built on a dual-pointer circular buffer. It fronts a simple two-port memory: a producer pushes into the write side, and a consumer pops from the read side with a registered one-cycle read latency. The block owns pointer management, occupancy tracking, status flags and error flags. It is the producer/consumer-facing end of the memory interface and is intended as the standard buffering primitive between pipeline stages.

---
 rtl/sync_fifo_ctrl.sv | 139 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO over a dual-pointer circular buffer. The storage is an
// inferred two-port memory (one write port, one registered read port). This
// block owns the pointers, the occupancy count, the status flags and the
// one-cycle overflow/underflow pulses.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   wr_en        in   push request
//   din          in   push data, written when the push is accepted
//   rd_en        in   pop request
//   dout         out  popped word, registered (1-cycle read latency)
//   dout_valid   out  dout holds the word of a pop accepted last cycle
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  occupancy 0..DEPTH
//   overflow     out  pulse: a push was rejected last cycle
//   underflow    out  pulse: a pop was rejected last cycle
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // All occupancy thresholds are held at count width so comparisons are exact.
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] ZERO_C  = '0;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q;
  logic [ADDR_WIDTH:0]   rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  full_q;
  logic                  empty_q;
  logic                  almost_full_q;
  logic                  almost_empty_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  push_ok;
  logic                  pop_ok;

  // Acceptance uses the registered flags. Because a pop needs ~empty, the
  // read slot can never equal the slot written in the same cycle.
  assign push_ok = wr_en & ~full_q;
  assign pop_ok  = rd_en & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (AF_LEVEL == 0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + ONE_C;
      end
      // dout holds its last value when no pop is accepted.
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + ONE_C;
        dout_q   <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
      dout_valid_q   <= pop_ok;
      count_q        <= count_d;
      // Flags come from the next-state count so they line up with count.
      full_q         <= (count_d == DEPTH_C);
      empty_q        <= (count_d == ZERO_C);
      almost_full_q  <= (count_d >= AF_C);
      almost_empty_q <= (count_d <= AE_C);
      overflow_q     <= wr_en & full_q;
      underflow_q    <= rd_en & empty_q;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
//
// Directed bench for sync_fifo_ctrl with default parameters (DEPTH = 32,
// AF_LEVEL = 28, AE_LEVEL = 4). Inputs change 1 time unit after the rising
// edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [5:0] count;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  sync_fifo_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (5),
    .AF_LEVEL   (28),
    .AE_LEVEL   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;

    // 1. Reset and idle.
    tick();
    tick();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {26'd0, count}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_dvalid", {31'd0, dout_valid}, 32'd0);
    check("rst_ae", {31'd0, almost_empty}, 32'd1);
    check("rst_af", {31'd0, almost_full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_unf", {31'd0, underflow}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("rel_empty", {31'd0, empty}, 32'd1);
    check("rel_count", {26'd0, count}, 32'd0);
    check("rel_dvalid", {31'd0, dout_valid}, 32'd0);
    $display("step reset/idle done count=%0d empty=%0d", count, empty);

    // 2. Fill to full, then one rejected push.
    for (int i = 1; i <= 32; i++) begin
      wr_en = 1'b1;
      din   = 8'(i);
      tick();
      check("fill_count", {26'd0, count}, 32'(i));
      check("fill_af", {31'd0, almost_full}, (i >= 28) ? 32'd1 : 32'd0);
      check("fill_full", {31'd0, full}, (i == 32) ? 32'd1 : 32'd0);
      $display("push din=0x%02h count=%0d af=%0d full=%0d", din, count, almost_full, full);
    end
    din = 8'hFF;
    tick();
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    check("ovf_count", {26'd0, count}, 32'd32);
    $display("push rejected din=0xff overflow=%0d count=%0d", overflow, count);
    wr_en = 1'b0;
    tick();
    check("ovf_clear", {31'd0, overflow}, 32'd0);

    // 3. Drain, then one rejected pop.
    for (int i = 1; i <= 32; i++) begin
      rd_en = 1'b1;
      tick();
      check("drain_dout", {24'd0, dout}, 32'(i));
      check("drain_dvalid", {31'd0, dout_valid}, 32'd1);
      check("drain_count", {26'd0, count}, 32'(32 - i));
      check("drain_empty", {31'd0, empty}, (i == 32) ? 32'd1 : 32'd0);
      check("drain_ae", {31'd0, almost_empty}, ((32 - i) <= 4) ? 32'd1 : 32'd0);
      $display("pop dout=0x%02h valid=%0d count=%0d", dout, dout_valid, count);
    end
    tick();
    check("unf_pulse", {31'd0, underflow}, 32'd1);
    check("unf_dout_hold", {24'd0, dout}, 32'h20);
    check("unf_dvalid", {31'd0, dout_valid}, 32'd0);
    $display("pop rejected underflow=%0d dout=0x%02h", underflow, dout);
    rd_en = 1'b0;
    tick();
    check("unf_clear", {31'd0, underflow}, 32'd0);

    // 4. Wrap-around: fill 20, pop 20, fill 30, pop 30.
    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 8'(8'h40 + i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("wrap1_dout", {24'd0, dout}, 32'(8'h40 + i));
    end
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      din = 8'(8'h80 + i);
      tick();
    end
    wr_en = 1'b0;
    check("wrap_count30", {26'd0, count}, 32'd30);
    $display("wrap fill count=%0d", count);
    rd_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("wrap2_dout", {24'd0, dout}, 32'(8'h80 + i));
      check("wrap2_dvalid", {31'd0, dout_valid}, 32'd1);
      $display("wrap pop dout=0x%02h count=%0d", dout, count);
    end
    rd_en = 1'b0;
    check("wrap_empty", {31'd0, empty}, 32'd1);

    // 5. Simultaneous push/pop at full, then at empty.
    wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      din = 8'(8'hA0 + i);
      tick();
    end
    check("sim_full", {31'd0, full}, 32'd1);
    rd_en = 1'b1;
    din   = 8'h55;
    tick();
    check("simf_count", {26'd0, count}, 32'd31);
    check("simf_ovf", {31'd0, overflow}, 32'd1);
    check("simf_dout", {24'd0, dout}, 32'hA0);
    check("simf_dvalid", {31'd0, dout_valid}, 32'd1);
    check("simf_full", {31'd0, full}, 32'd0);
    $display("push+pop at full count=%0d overflow=%0d dout=0x%02h", count, overflow, dout);
    wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      tick();
      check("simf_drain", {24'd0, dout}, 32'(8'hA0 + i));
    end
    check("sime_pre_empty", {31'd0, empty}, 32'd1);
    wr_en = 1'b1;
    din   = 8'h77;
    tick();
    check("sime_count", {26'd0, count}, 32'd1);
    check("sime_unf", {31'd0, underflow}, 32'd1);
    check("sime_dvalid", {31'd0, dout_valid}, 32'd0);
    check("sime_dout_hold", {24'd0, dout}, 32'hBF);
    check("sime_empty", {31'd0, empty}, 32'd0);
    $display("push+pop at empty count=%0d underflow=%0d valid=%0d", count, underflow, dout_valid);
    wr_en = 1'b0;
    tick();
    check("sime_pop_dout", {24'd0, dout}, 32'h77);
    check("sime_pop_dvalid", {31'd0, dout_valid}, 32'd1);
    rd_en = 1'b0;
    tick();
    check("sime_final_count", {26'd0, count}, 32'd0);

    // 6. Asynchronous reset during a push burst at count=10.
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 8'(8'hC0 + i);
      tick();
    end
    check("burst_count10", {26'd0, count}, 32'd10);
    din = 8'hCA;
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", {26'd0, count}, 32'd0);
    check("arst_empty", {31'd0, empty}, 32'd1);
    check("arst_dout", {24'd0, dout}, 32'd0);
    $display("async reset count=%0d empty=%0d", count, empty);
    wr_en = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    wr_en = 1'b1;
    din   = 8'h33;
    tick();
    check("post_dvalid", {31'd0, dout_valid}, 32'd0);
    din = 8'h34;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    check("post_pop_dout", {24'd0, dout}, 32'h33);
    check("post_pop_dvalid", {31'd0, dout_valid}, 32'd1);
    check("post_pop_count", {26'd0, count}, 32'd1);
    $display("post-reset pop dout=0x%02h count=%0d", dout, count);
    rd_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
